// File: rtl/lcd_controller_if.sv
// rtl/lcd_controller_if.sv - CPU-side byte request handshake for the character LCD sequencer
interface lcd_controller_if;
    logic       req_valid;
    logic       req_rs;
    logic [7:0] req_data;
    logic       req_ready;

    modport master (
        output req_valid,
        output req_rs,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_rs,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/lcd_controller.sv
// rtl/lcd_controller.sv - HD44780 8-bit init plus per-byte setup/enable/hold/exec-wait pin sequencer
module lcd_controller #(
    parameter int unsigned POWERUP_CYCLES    = 750000,
    parameter int unsigned SETUP_CYCLES      = 3,
    parameter int unsigned PULSE_CYCLES      = 12,
    parameter int unsigned HOLD_CYCLES       = 2,
    parameter int unsigned CMD_WAIT_CYCLES   = 2000,
    parameter int unsigned CLEAR_WAIT_CYCLES = 82000
) (
    input  logic              clk,
    input  logic              rst_in,
    lcd_controller_if.slave   req,
    output logic              init_done,
    output logic [10:0]       lcd_pins
);

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    localparam logic [19:0] LD_POWERUP = 20'(POWERUP_CYCLES - 1);
    localparam logic [19:0] LD_SETUP   = 20'(SETUP_CYCLES - 1);
    localparam logic [19:0] LD_PULSE   = 20'(PULSE_CYCLES - 1);
    localparam logic [19:0] LD_HOLD    = 20'(HOLD_CYCLES - 1);
    localparam logic [19:0] LD_CMD     = 20'(CMD_WAIT_CYCLES - 1);
    localparam logic [19:0] LD_CLEAR   = 20'(CLEAR_WAIT_CYCLES - 1);
    localparam logic [2:0]  LAST_INIT  = 3'd5;

    state_t      state, state_n;
    logic [19:0] cnt, cnt_n;
    logic [2:0]  init_idx, idx_n;
    logic        cur_rs, cur_rs_n;
    logic [7:0]  cur_data, cur_data_n;
    logic        done_n;
    logic        is_clear;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_byte = 8'h38;
            3'd3:             init_byte = 8'h0C;
            3'd4:             init_byte = 8'h01;
            default:          init_byte = 8'h06;
        endcase
    endfunction

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    assign is_clear = !cur_rs && (cur_data[7:2] == 6'd0) && (cur_data[1:0] != 2'd0);

    assign req.req_ready = (state == ST_IDLE) && init_done;

    always_comb begin
        state_n    = state;
        cnt_n      = (cnt != 20'd0) ? cnt - 20'd1 : cnt;
        idx_n      = init_idx;
        cur_rs_n   = cur_rs;
        cur_data_n = cur_data;
        done_n     = init_done;
        case (state)
            ST_POWERUP: begin
                if (cnt == 20'd0) begin
                    state_n    = ST_SETUP;
                    cnt_n      = LD_SETUP;
                    cur_rs_n   = 1'b0;
                    cur_data_n = init_byte(3'd0);
                end
            end
            ST_IDLE: begin
                if (req.req_valid && req.req_ready) begin
                    state_n    = ST_SETUP;
                    cnt_n      = LD_SETUP;
                    cur_rs_n   = req.req_rs;
                    cur_data_n = req.req_data;
                end
            end
            ST_SETUP: begin
                if (cnt == 20'd0) begin
                    state_n = ST_PULSE;
                    cnt_n   = LD_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt == 20'd0) begin
                    state_n = ST_HOLD;
                    cnt_n   = LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt == 20'd0) begin
                    state_n = ST_WAIT;
                    cnt_n   = is_clear ? LD_CLEAR : LD_CMD;
                end
            end
            ST_WAIT: begin
                if (cnt == 20'd0) begin
                    if (init_done) begin
                        state_n = ST_IDLE;
                    end else if (init_idx == LAST_INIT) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        // Init bytes chain straight into the next SETUP with no IDLE gap.
                        idx_n      = init_idx + 3'd1;
                        cur_rs_n   = 1'b0;
                        cur_data_n = init_byte(init_idx + 3'd1);
                        state_n    = ST_SETUP;
                        cnt_n      = LD_SETUP;
                    end
                end
            end
            default: begin
                state_n = ST_POWERUP;
                cnt_n   = LD_POWERUP;
            end
        endcase
    end

    // Pins are derived from next-state values so they change exactly on state-entry edges.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state     <= ST_POWERUP;
            cnt       <= LD_POWERUP;
            init_idx  <= 3'd0;
            cur_rs    <= 1'b0;
            cur_data  <= 8'h00;
            init_done <= 1'b0;
            lcd_pins  <= 11'h000;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            init_idx  <= idx_n;
            cur_rs    <= cur_rs_n;
            cur_data  <= cur_data_n;
            init_done <= done_n;
            lcd_pins  <= {cur_rs_n, 1'b0, (state_n == ST_PULSE), cur_data_n};
        end
    end

endmodule

// File: tb/tb_lcd_controller.sv
// tb/tb_lcd_controller.sv - self-checking bench for lcd_controller with a timing/pulse reference model
module tb_lcd_controller;

    localparam int PW = 5;
    localparam int S  = 2;
    localparam int P  = 3;
    localparam int H  = 1;
    localparam int WC = 4;
    localparam int WL = 10;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        init_done;
    logic [10:0] lcd_pins;

    lcd_controller_if ifc();

    lcd_controller #(
        .POWERUP_CYCLES(PW), .SETUP_CYCLES(S), .PULSE_CYCLES(P),
        .HOLD_CYCLES(H), .CMD_WAIT_CYCLES(WC), .CLEAR_WAIT_CYCLES(WL)
    ) dut (
        .clk(clk),
        .rst_in(rst_in),
        .req(ifc),
        .init_done(init_done),
        .lcd_pins(lcd_pins)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] init_rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    function automatic int exp_wait(input logic rs, input logic [7:0] d);
        return (rs == 1'b0 && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? WL : WC;
    endfunction

    // Enable-pulse monitor: records every completed E pulse.
    logic       prev_e = 1'b0;
    int         rise_c = 0;
    logic [10:0] rise_word = 11'h0;
    logic [7:0] mon_data[$];
    logic       mon_rs[$];
    int         mon_width[$];
    int         mon_rise[$];
    int         mon_fall[$];
    logic       mon_stable[$];

    always @(negedge clk) begin
        if (lcd_pins[8] && !prev_e) begin
            rise_c    <= cyc;
            rise_word <= lcd_pins;
        end
        if (!lcd_pins[8] && prev_e) begin
            mon_data.push_back(lcd_pins[7:0]);
            mon_rs.push_back(lcd_pins[10]);
            mon_width.push_back(cyc - rise_c);
            mon_rise.push_back(rise_c);
            mon_fall.push_back(cyc);
            mon_stable.push_back({rise_word[10:9], rise_word[7:0]} == {lcd_pins[10:9], lcd_pins[7:0]});
        end
        prev_e <= lcd_pins[8];
    end

    task automatic clear_mon();
        mon_data.delete(); mon_rs.delete(); mon_width.delete();
        mon_rise.delete(); mon_fall.delete(); mon_stable.delete();
    endtask

    logic       s_rs[4];
    logic [7:0] s_dat[4];
    int         acc[5];

    task automatic test_reset();
        ifc.req_valid = 1'b0; ifc.req_rs = 1'b0; ifc.req_data = 8'h00;
        rst_in = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (lcd_pins !== 11'h000) begin n_err++; $display("FAIL reset_pins got=%h exp=000", lcd_pins); end
        n_cmp++; if (ifc.req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", ifc.req_ready); end
        n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", init_done); end
        rst_in = 1'b1;
        for (int i = 1; i <= PW; i++) begin
            logic [10:0] exp;
            @(negedge clk);
            exp = (i < PW) ? 11'h000 : 11'h038;
            n_cmp++;
            if (lcd_pins !== exp) begin n_err++; $display("FAIL powerup_cycle%0d got=%h exp=%h", i, lcd_pins, exp); end
        end
    endtask

    task automatic test_init();
        int guard = 0;
        int done_c = 0;
        while (init_done !== 1'b1 && guard < 500) begin @(negedge clk); guard++; end
        done_c = cyc;
        n_cmp++; if (init_done !== 1'b1) begin n_err++; $display("FAIL init_done_timeout got=%b exp=1", init_done); end
        n_cmp++; if (ifc.req_ready !== 1'b1) begin n_err++; $display("FAIL init_ready_with_done got=%b exp=1", ifc.req_ready); end
        n_cmp++; if (mon_data.size() != 6) begin n_err++; $display("FAIL init_pulse_count got=%0d exp=6", mon_data.size()); end
        for (int i = 0; i < 6 && i < mon_data.size(); i++) begin
            n_cmp++;
            if (mon_data[i] !== init_rom[i] || mon_rs[i] !== 1'b0 || mon_width[i] != P || mon_stable[i] !== 1'b1) begin
                n_err++;
                $display("FAIL init_byte%0d got=rs%b/%h/w%0d/st%b exp=rs0/%h/w%0d/st1", i, mon_rs[i], mon_data[i], mon_width[i], mon_stable[i], init_rom[i], P);
            end
            if (i < 5 && i + 1 < mon_rise.size()) begin
                int gap = mon_rise[i+1] - mon_fall[i];
                int eg  = H + exp_wait(1'b0, init_rom[i]) + S;
                n_cmp++;
                if (gap != eg) begin n_err++; $display("FAIL init_gap%0d got=%0d exp=%0d", i, gap, eg); end
            end
        end
        if (mon_fall.size() == 6) begin
            n_cmp++;
            if (done_c - mon_fall[5] != H + WC) begin n_err++; $display("FAIL init_last_wait got=%0d exp=%0d", done_c - mon_fall[5], H + WC); end
        end
    endtask

    task automatic do_txn(input logic rs, input logic [7:0] d);
        int tot;
        logic [11:0] exp, got;
        logic e_exp, r_exp;
        tot = S + P + H + exp_wait(rs, d);
        @(negedge clk);
        n_cmp++; if (ifc.req_ready !== 1'b1) begin n_err++; $display("FAIL txn_ready_before got=%b exp=1", ifc.req_ready); end
        ifc.req_valid = 1'b1; ifc.req_rs = rs; ifc.req_data = d;
        @(posedge clk); #1;
        ifc.req_valid = 1'b0; ifc.req_rs = ~rs; ifc.req_data = ~d;
        for (int c = 1; c <= tot + 1; c++) begin
            @(negedge clk);
            e_exp = (c >= S + 1) && (c <= S + P);
            r_exp = (c == tot + 1);
            exp = {r_exp, rs, 1'b0, e_exp, d};
            got = {ifc.req_ready, lcd_pins};
            n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL txn_rs%b_%h_cycle%0d got=%h exp=%h", rs, d, c, got, exp); end
        end
    endtask

    task automatic test_data_write();
        do_txn(1'b1, 8'h41);
    endtask

    task automatic test_random_writes();
        for (int i = 0; i < 12; i++) begin
            logic rs;
            logic [7:0] d;
            rs = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
            do_txn(rs, d);
        end
    endtask

    // Holds req_valid high; the byte is junk except on the cycle whose edge accepts.
    task automatic run_stream(input int n);
        int k = 0;
        int guard = 0;
        ifc.req_valid = 1'b1; ifc.req_rs = 1'($urandom); ifc.req_data = 8'($urandom);
        while (k < n && guard < 400) begin
            @(negedge clk);
            guard++;
            if (ifc.req_ready === 1'b1) begin
                ifc.req_rs = s_rs[k]; ifc.req_data = s_dat[k];
                acc[k] = cyc;
                k++;
                @(posedge clk); #1;
                if (k < n) begin ifc.req_rs = 1'($urandom); ifc.req_data = 8'($urandom); end
                else ifc.req_valid = 1'b0;
            end else begin
                ifc.req_rs = 1'($urandom); ifc.req_data = 8'($urandom);
            end
        end
        ifc.req_valid = 1'b0;
        do begin @(negedge clk); guard++; end while (ifc.req_ready !== 1'b1 && guard < 400);
        acc[n] = cyc;
        n_cmp++;
        if (k != n || ifc.req_ready !== 1'b1) begin n_err++; $display("FAIL stream_timeout got=%0d exp=%0d", k, n); end
    endtask

    task automatic test_clear_vs_normal();
        s_rs[0] = 1'b0; s_dat[0] = 8'h01;
        s_rs[1] = 1'b1; s_dat[1] = 8'h01;
        run_stream(2);
        n_cmp++;
        if (acc[1] - acc[0] != S + P + H + WL + 1) begin n_err++; $display("FAIL clear_spacing got=%0d exp=%0d", acc[1] - acc[0], S + P + H + WL + 1); end
        n_cmp++;
        if (acc[2] - acc[1] != S + P + H + WC + 1) begin n_err++; $display("FAIL normal_spacing got=%0d exp=%0d", acc[2] - acc[1], S + P + H + WC + 1); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        clear_mon();
        for (int i = 0; i < 3; i++) begin s_rs[i] = 1'b1; s_dat[i] = 8'h10 + 8'(i); end
        run_stream(3);
        n_cmp++; if (mon_data.size() != 3) begin n_err++; $display("FAIL b2b_pulse_count got=%0d exp=3", mon_data.size()); end
        for (int i = 0; i < 3 && i < mon_data.size(); i++) begin
            n_cmp++;
            if (mon_data[i] !== s_dat[i] || mon_rs[i] !== 1'b1 || mon_width[i] != P) begin
                n_err++;
                $display("FAIL b2b_byte%0d got=rs%b/%h/w%0d exp=rs1/%h/w%0d", i, mon_rs[i], mon_data[i], mon_width[i], s_dat[i], P);
            end
            n_cmp++;
            if (acc[i+1] - acc[i] != S + P + H + WC + 1) begin n_err++; $display("FAIL b2b_spacing%0d got=%0d exp=%0d", i, acc[i+1] - acc[i], S + P + H + WC + 1); end
        end
    endtask

    task automatic test_reset_mid_op();
        int guard = 0;
        logic early = 1'b0;
        @(negedge clk);
        ifc.req_valid = 1'b1; ifc.req_rs = 1'b1; ifc.req_data = 8'($urandom);
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        do begin @(negedge clk); guard++; end while (lcd_pins[8] !== 1'b1 && guard < 20);
        n_cmp++; if (lcd_pins[8] !== 1'b1) begin n_err++; $display("FAIL midrst_pulse_seen got=%b exp=1", lcd_pins[8]); end
        #2 rst_in = 1'b0;
        #1;
        n_cmp++;
        if ({init_done, ifc.req_ready, lcd_pins} !== 13'h0) begin
            n_err++; $display("FAIL midrst_async got=%h exp=0000", {init_done, ifc.req_ready, lcd_pins});
        end
        @(negedge clk); rst_in = 1'b1;
        @(posedge clk); #1;
        clear_mon();
        guard = 0;
        while (init_done !== 1'b1 && guard < 400) begin
            @(negedge clk); guard++;
            if (init_done === 1'b1 && mon_data.size() < 6) early = 1'b1;
        end
        n_cmp++; if (early !== 1'b0 || init_done !== 1'b1) begin n_err++; $display("FAIL midrst_done got=early%b/done%b exp=early0/done1", early, init_done); end
        n_cmp++; if (mon_data.size() != 6) begin n_err++; $display("FAIL midrst_pulse_count got=%0d exp=6", mon_data.size()); end
        for (int i = 0; i < 6 && i < mon_data.size(); i++) begin
            n_cmp++;
            if (mon_data[i] !== init_rom[i] || mon_rs[i] !== 1'b0) begin
                n_err++; $display("FAIL midrst_byte%0d got=rs%b/%h exp=rs0/%h", i, mon_rs[i], mon_data[i], init_rom[i]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_init();
        test_data_write();
        test_random_writes();
        test_clear_vs_normal();
        test_back_to_back();
        test_reset_mid_op();
        test_data_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
